// File: rtl/rf_op_sequencer.sv
// Register-file instruction sequencer: reads two operands, runs a 16-bit ALU op,
// and writes the result back through the file's write port in a fixed 4-cycle slot.
`timescale 1ns/1ps
module rf_op_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_sel_a,
  input  logic [ADDR_W-1:0] instr_sel_b,
  input  logic [ADDR_W-1:0] instr_dst,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] d_out_a,
  input  logic [DATA_W-1:0] d_out_b,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              done
);

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_NOT = 3'd5;
  localparam logic [OP_W-1:0] OP_MOV = 3'd6;
  localparam logic [OP_W-1:0] OP_CMP = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [OP_W-1:0]   op_q, op_nxt;
  logic [ADDR_W-1:0] dst_q, dst_nxt;
  logic [DATA_W-1:0] op_a, op_a_nxt;
  logic [DATA_W-1:0] op_b, op_b_nxt;
  logic [ADDR_W-1:0] rd_addr_a_nxt, rd_addr_b_nxt, wr_addr_nxt;
  logic [DATA_W-1:0] d_in_nxt, result_nxt;
  logic              carry_nxt, zero_nxt, wr_nxt, done_nxt, ready_nxt;

  logic [DATA_W:0]   sum_ext, diff_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  // ALU on the captured operands; carry is bit DATA_W of the extended sum/difference
  always_comb begin
    sum_ext   = {1'b0, op_a} + {1'b0, op_b};
    diff_ext  = {1'b0, op_a} - {1'b0, op_b};
    alu_res   = op_a;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res   = sum_ext[DATA_W-1:0];
        alu_carry = sum_ext[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        alu_res   = diff_ext[DATA_W-1:0];
        alu_carry = diff_ext[DATA_W];
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOT:  alu_res = ~op_a;
      OP_MOV:  alu_res = op_a;
      default: alu_res = op_a;
    endcase
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt     = state;
    op_nxt        = op_q;
    dst_nxt       = dst_q;
    op_a_nxt      = op_a;
    op_b_nxt      = op_b;
    rd_addr_a_nxt = rd_addr_a;
    rd_addr_b_nxt = rd_addr_b;
    wr_addr_nxt   = wr_addr;
    d_in_nxt      = d_in;
    result_nxt    = result;
    carry_nxt     = carry;
    zero_nxt      = zero;
    wr_nxt        = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          op_nxt        = instr_op;
          dst_nxt       = instr_dst;
          rd_addr_a_nxt = instr_sel_a;
          rd_addr_b_nxt = instr_sel_b;
          state_nxt     = READ;
        end
      end
      READ: begin
        op_a_nxt  = d_out_a;
        op_b_nxt  = d_out_b;
        state_nxt = EXEC;
      end
      EXEC: begin
        result_nxt  = alu_res;
        carry_nxt   = alu_carry;
        zero_nxt    = (alu_res == '0);
        d_in_nxt    = alu_res;
        wr_addr_nxt = dst_q;
        wr_nxt      = (op_q != OP_CMP);
        done_nxt    = 1'b1;
        state_nxt   = WRITE;
      end
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // ready is a registered copy of "next state is IDLE", so it mirrors state == IDLE
    ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      op_q        <= '0;
      dst_q       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      rd_addr_a   <= '0;
      rd_addr_b   <= '0;
      wr_addr     <= '0;
      d_in        <= '0;
      result      <= '0;
      carry       <= 1'b0;
      zero        <= 1'b0;
      wr          <= 1'b0;
      done        <= 1'b0;
      instr_ready <= 1'b1;
    end else begin
      state       <= state_nxt;
      op_q        <= op_nxt;
      dst_q       <= dst_nxt;
      op_a        <= op_a_nxt;
      op_b        <= op_b_nxt;
      rd_addr_a   <= rd_addr_a_nxt;
      rd_addr_b   <= rd_addr_b_nxt;
      wr_addr     <= wr_addr_nxt;
      d_in        <= d_in_nxt;
      result      <= result_nxt;
      carry       <= carry_nxt;
      zero        <= zero_nxt;
      wr          <= wr_nxt;
      done        <= done_nxt;
      instr_ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Bench for rf_op_sequencer: behavioural 8x16 register file plus an arithmetic
// reference model; directed cases from the plan followed by randomized instructions.
`timescale 1ns/1ps
module tb_rf_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic [2:0]  instr_sel_a, instr_sel_b, instr_dst;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] d_out_a, d_out_b, d_in, result;
  logic        wr, carry, zero, done;

  logic [15:0] rf [8];
  logic [15:0] exp_rf [8];
  logic        preload;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rf_op_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_sel_a(instr_sel_a), .instr_sel_b(instr_sel_b),
    .instr_dst(instr_dst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .d_out_a(d_out_a), .d_out_b(d_out_b),
    .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
    .result(result), .carry(carry), .zero(zero), .done(done)
  );

  // Register file: combinational reads, write on the clock edge when wr=1
  assign d_out_a = rf[rd_addr_a];
  assign d_out_b = rf[rd_addr_b];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
      rf[1] <= 16'h00FF;
      rf[2] <= 16'h0F0F;
      rf[3] <= 16'hFFFF;
      rf[4] <= 16'h0001;
    end else if (wr) begin
      rf[wr_addr] <= d_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic c);
    int unsigned ua, ub, s;
    ua = 32'(a);
    ub = 32'(b);
    c  = 1'b0;
    r  = a;
    case (op)
      3'd0: begin s = ua + ub; r = 16'(s); c = (s > 32'd65535); end
      3'd1, 3'd7: begin r = 16'(ua + 32'd65536 - ub); c = (ua < ub); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      default: r = a;
    endcase
  endfunction

  task automatic check_rf(input string tag);
    for (int i = 0; i < 8; i++) check(tag, 32'(rf[i]), 32'(exp_rf[i]));
  endtask

  // One full instruction slot, checked cycle by cycle; hold keeps instr_valid high
  task automatic run_instr(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] d, input bit hold);
    logic [15:0] er;
    logic        ec, ez;
    int          n;
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    check("ready_wait", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr_op = op; instr_sel_a = a; instr_sel_b = b; instr_dst = d;
    ref_alu(op, exp_rf[a], exp_rf[b], er, ec);
    ez = (er == 16'h0000);
    @(negedge clk);
    if (!hold) instr_valid = 1'b0;
    instr_op = 3'($urandom); instr_sel_a = 3'($urandom);
    instr_sel_b = 3'($urandom); instr_dst = 3'($urandom);
    check("read_ready", 32'(instr_ready), 32'd0);
    check("rd_addr_a", 32'(rd_addr_a), 32'(a));
    check("rd_addr_b", 32'(rd_addr_b), 32'(b));
    check("read_wr", 32'(wr), 32'd0);
    check("read_done", 32'(done), 32'd0);
    @(negedge clk);
    check("exec_ready", 32'(instr_ready), 32'd0);
    check("exec_wr", 32'(wr), 32'd0);
    check("exec_done", 32'(done), 32'd0);
    @(negedge clk);
    check("write_ready", 32'(instr_ready), 32'd0);
    check("write_done", 32'(done), 32'd1);
    check("write_wr", 32'(wr), 32'(op != 3'd7));
    check("wr_addr", 32'(wr_addr), 32'(d));
    check("d_in", 32'(d_in), 32'(er));
    check("result", 32'(result), 32'(er));
    check("carry", 32'(carry), 32'(ec));
    check("zero", 32'(zero), 32'(ez));
    if (op != 3'd7) exp_rf[d] = er;
    @(negedge clk);
    check("idle_ready", 32'(instr_ready), 32'd1);
    check("idle_done", 32'(done), 32'd0);
    check("idle_wr", 32'(wr), 32'd0);
    check("result_held", 32'(result), 32'(er));
    check_rf("rf");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rop, ra, rb, rd;
    bit         hold;

    reset = 1'b0; preload = 1'b1; instr_valid = 1'b0;
    instr_op = '0; instr_sel_a = '0; instr_sel_b = '0; instr_dst = '0;
    for (int i = 0; i < 8; i++) exp_rf[i] = 16'h0000;
    exp_rf[1] = 16'h00FF; exp_rf[2] = 16'h0F0F; exp_rf[3] = 16'hFFFF; exp_rf[4] = 16'h0001;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_d_in", 32'(d_in), 32'd0);
    check("rst_rd_addr_a", 32'(rd_addr_a), 32'd0);
    preload = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // ADD R5 = R3 + R4 wraps to zero with carry
    run_instr(3'd0, 3'd3, 3'd4, 3'd5, 1'b0);
    check("add_r5", 32'(rf[5]), 32'h0000);
    check("add_carry", 32'(carry), 32'd1);
    // SUB R6 = R4 - R1 borrows
    run_instr(3'd1, 3'd4, 3'd1, 3'd6, 1'b0);
    check("sub_r6", 32'(rf[6]), 32'hFF02);
    // CMP R1, R1 sets zero, writes nothing
    run_instr(3'd7, 3'd1, 3'd1, 3'd2, 1'b0);
    check("cmp_zero", 32'(zero), 32'd1);
    check("cmp_r2", 32'(rf[2]), 32'h0F0F);
    // Back-to-back AND/OR/XOR into R7 with instr_valid held
    run_instr(3'd2, 3'd1, 3'd2, 3'd7, 1'b1);
    check("and_r7", 32'(rf[7]), 32'h000F);
    run_instr(3'd3, 3'd1, 3'd2, 3'd7, 1'b1);
    check("or_r7", 32'(rf[7]), 32'h0FFF);
    run_instr(3'd4, 3'd1, 3'd2, 3'd7, 1'b0);
    check("xor_r7", 32'(rf[7]), 32'h0FF0);
    // Dependent pair through R0
    run_instr(3'd6, 3'd2, 3'd5, 3'd0, 1'b0);
    run_instr(3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    check("dep_r0", 32'(rf[0]), 32'h1E1E);
    check("dep_carry", 32'(carry), 32'd0);

    // Reset between edges during EXEC of ADD R5 = R1 + R2
    instr_valid = 1'b1; instr_op = 3'd0; instr_sel_a = 3'd1; instr_sel_b = 3'd2; instr_dst = 3'd5;
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    instr_valid = 1'b1;
    #1;
    check("arst_wr", 32'(wr), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_carry", 32'(carry), 32'd0);
    check("arst_rd_addr_a", 32'(rd_addr_a), 32'd0);
    check("arst_ready", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("inrst_wr", 32'(wr), 32'd0);
      check("inrst_done", 32'(done), 32'd0);
      check("inrst_rd_addr_b", 32'(rd_addr_b), 32'd0);
    end
    instr_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(instr_ready), 32'd1);
    check("post_rst_rd_addr_a", 32'(rd_addr_a), 32'd0);
    check("post_rst_r5", 32'(rf[5]), 32'h0000);
    check_rf("post_rst_rf");

    // Reset dropped inside the WRITE cycle clears wr at once and blocks the write
    instr_valid = 1'b1; instr_op = 3'd6; instr_sel_a = 3'd1; instr_sel_b = 3'd0; instr_dst = 3'd6;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("write_wr_pre", 32'(wr), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("wrst_wr", 32'(wr), 32'd0);
    check("wrst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_rf("wrst_rf");

    // Randomized instruction stream
    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom); ra = 3'($urandom); rb = 3'($urandom); rd = 3'($urandom);
      hold = ($urandom_range(0, 1) == 1) && (k != 39);
      run_instr(rop, ra, rb, rd, hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    instr_valid = 1'b0;
    @(negedge clk);
    check("final_ready", 32'(instr_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
